sysa_seq: RTL and testbench
===========================

// Module: sysa_seq
// PURPOSE
//  Sequencer for the NxN weight-stationary systolic array (sysa). Loads the N*N
//  weight word row by row, accepts activation vectors on a valid/ready stream,
//  applies the per-row input skew, freezes the array under output backpressure,
//  de-skews the N column sums, and returns one aligned result per vector.
// PARAMETERS
//  N   3   array dimension (rows = columns = N)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  w_valid    in   1        weight-row beat valid
//  w_ready    out  1        weight-row beat accepted when w_valid&w_ready
//  w_data     in   8*N      one weight row; element c in [8c+:8]
//  in_valid   in   1        activation vector valid
//  in_ready   out  1        activation vector accepted when in_valid&in_ready
//  in_data    in   8*N      activation vector; element k in [8k+:8] feeds array row k
//  in_last    in   1        marks final vector of a job
//  out_valid  out  1        aligned result valid
//  out_ready  in   1        result consumed when out_valid&out_ready
//  out_data   out  16*N     column sums; column c in [16c+:16]
//  done       out  1        one-cycle pulse when a job fully drains
//  sa_en      out  1        array enable
//  sa_w       out  8*N*N    array weights; row r col c in [8*(r*N+c)+:8]
//  sa_in      out  8*N      skewed array row inputs
//  sa_out     in   16*N     array bottom-row outputs, column c in [16c+:16]
// BEHAVIOUR
//  Reset: state IDLE; w_ready=1, in_ready=0, out_valid=0, done=0, sa_en=0,
//   sa_w=0, sa_in=0, out_data=0, row counter 0, wloaded=0, pipes cleared.
//   Reset mid-job discards all in-flight vectors; nothing emitted afterwards.
//  FSM: IDLE, LOAD, RUN, DRAIN.
//   IDLE: w_ready=1; in_ready=wloaded. Weight beat -> write row 0, clear wloaded,
//    go LOAD. Vector beat -> RUN (DRAIN if in_last). Weight beat wins if both fire.
//   LOAD: w_ready=1, in_ready=0; beat writes row[cnt], cnt++; after row N-1:
//    cnt->0, wloaded=1, -> IDLE.
//   RUN: w_ready=0; in_ready=!stall. Beat with in_last -> DRAIN.
//   DRAIN: w_ready=0, in_ready=0; bubbles injected; when valid pipe empty and
//    out_valid=0 -> IDLE, done=1 for that cycle. Weights retained.
//  Stall = out_valid & !out_ready. During stall sa_en=0 and skew, de-skew and valid
//   pipes hold; otherwise sa_en=1 in RUN/DRAIN, 0 in IDLE/LOAD.
//  Skew: vector accepted at enabled cycle T drives element k on sa_in[k] at T+1+k;
//   cycles without an accepted vector inject zero with valid tag 0.
//  De-skew: sa_out column c delayed N-1-c enabled cycles; aligned word captured
//   into out_data with valid tag. out_valid rises at T+2N+1 (7 for N=3),
//   counting enabled cycles only. One result per cycle at full throughput.
//  out_data/out_valid held stable while stalled; bubble tags never raise out_valid.
//  Arithmetic: controller does no math; 16-bit sums pass through unmodified.
// CONFIGURATION
//  SYSA_PERF_EN defined: adds ports perf_busy[31:0] (cycles in RUN/DRAIN) and
//   perf_stall[31:0] (stall cycles), both out, reset 0, cleared on entry to RUN,
//   saturate at 32'hFFFFFFFF. Undefined: ports and counters absent; rest identical.
// TESTING
//  Load weights all 8'd1; vector (1,2,3) last -> out_data cols=(6,6,6) 7 cycles after accept; done pulses.
//  Identity weights; 4 back-to-back vectors, out_ready=1 -> 4 results on 4 consecutive cycles, each = input.
//  Same stream, out_ready=0 for 5 cycles at first result -> sa_en=0, out_data held, no loss/dup, order kept.
//  w_valid asserted in RUN -> w_ready=0, sa_w unchanged; in_valid in LOAD -> in_ready=0.
//  rst pulse with 2 vectors in flight -> all outputs reset values, no out_valid until new job.
//  SYSA_PERF_EN: 3-cycle stall during job -> perf_stall=3, perf_busy=job cycle count.

Source files
------------

// File: rtl/sysa_seq.sv
`default_nettype none
//============================================================================
// Module      : sysa_seq
// Description : Sequencer for an NxN weight-stationary systolic array.
//               Loads weights row by row, streams activation vectors with
//               per-row input skew, freezes the array under output
//               backpressure and de-skews the column sums into one aligned
//               result per vector.
//               Optional macro SYSA_PERF_EN adds busy/stall perf counters.
// Revision    : 1.0 - initial release
//============================================================================
module sysa_seq #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [8*N-1:0]    w_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8*N-1:0]    in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [16*N-1:0]   out_data,
    output logic              done,
    output logic              sa_en,
    output logic [8*N*N-1:0]  sa_w,
    output logic [8*N-1:0]    sa_in,
`ifdef SYSA_PERF_EN
    output logic [31:0]       perf_busy,
    output logic [31:0]       perf_stall,
`endif
    input  logic [16*N-1:0]   sa_out
);

    localparam int              c_CW       = (N > 1) ? $clog2(N) : 1;
    localparam int              c_VD       = 2 * N;
    localparam logic [c_CW-1:0] c_LAST_ROW = c_CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic              r_wloaded;
    logic              w_wloaded_nxt;
    logic              w_we;
    logic [c_CW-1:0]   w_row;
    logic [8*N*N-1:0]  r_w;
    logic              w_stall;
    logic              w_adv;
    logic              w_acc;
    logic [c_VD-1:0]   r_vpipe;
    logic              r_out_valid;
    logic [16*N-1:0]   r_out_data;
    logic [16*N-1:0]   w_aligned;

    // Output stalled: array, skew, de-skew and valid pipes all freeze together.
    assign w_stall = r_out_valid & ~out_ready;
    assign w_adv   = ~w_stall;
    // In IDLE a simultaneous weight beat takes priority, so the vector is not taken.
    assign w_acc   = in_valid & in_ready & ~((r_state == S_IDLE) & w_valid);

    assign sa_w      = r_w;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // State, weight-row counter and weights-loaded flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wloaded <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wloaded <= w_wloaded_nxt;
        end
    end

    // Next-state logic and handshake/enable outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_wloaded_nxt = r_wloaded;
        w_we          = 1'b0;
        w_row         = '0;
        w_ready       = 1'b0;
        in_ready      = 1'b0;
        sa_en         = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready  = 1'b1;
                in_ready = r_wloaded;
                if (w_valid) begin
                    w_we          = 1'b1;
                    w_row         = '0;
                    w_cnt_nxt     = c_CW'(1);
                    w_wloaded_nxt = 1'b0;
                    w_state_nxt   = S_LOAD;
                end else if (in_valid && r_wloaded) begin
                    w_state_nxt = in_last ? S_DRAIN : S_RUN;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    w_we  = 1'b1;
                    w_row = r_cnt;
                    if (r_cnt == c_LAST_ROW) begin
                        w_cnt_nxt     = '0;
                        w_wloaded_nxt = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CW'(1);
                    end
                end
            end
            S_RUN: begin
                in_ready = ~w_stall;
                sa_en    = ~w_stall;
                if (in_valid && !w_stall && in_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                sa_en = ~w_stall;
                if ((r_vpipe == '0) && !r_out_valid) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Stationary weight storage, written one row per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w <= '0;
        end else if (w_we) begin
            for (int r = 0; r < N; r++) begin
                if (w_row == c_CW'(r)) begin
                    r_w[8*N*r +: 8*N] <= w_data;
                end
            end
        end
    end

    // Input skew: row k sees its element k+1 cycles after acceptance.
    for (genvar k = 0; k < N; k++) begin : g_skew
        logic [7:0] r_sk [0:k];

        // Shift chain for row k; bubbles inject zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= k; j++) begin
                    r_sk[j] <= '0;
                end
            end else if (w_adv) begin
                r_sk[0] <= w_acc ? in_data[8*k +: 8] : 8'd0;
                for (int j = 1; j <= k; j++) begin
                    r_sk[j] <= r_sk[j-1];
                end
            end
        end

        assign sa_in[8*k +: 8] = r_sk[k];
    end

    // Output de-skew: column c delayed N-1-c cycles so all columns line up.
    for (genvar c = 0; c < N; c++) begin : g_deskew
        if (c == N - 1) begin : g_pass
            assign w_aligned[16*c +: 16] = sa_out[16*c +: 16];
        end else begin : g_dly
            logic [15:0] r_ds [0:N-2-c];

            // Delay chain for column c.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j <= N - 2 - c; j++) begin
                        r_ds[j] <= '0;
                    end
                end else if (w_adv) begin
                    r_ds[0] <= sa_out[16*c +: 16];
                    for (int j = 1; j <= N - 2 - c; j++) begin
                        r_ds[j] <= r_ds[j-1];
                    end
                end
            end

            assign w_aligned[16*c +: 16] = r_ds[N-2-c];
        end
    end

    // Valid-tag pipe tracking each vector to its aligned result, plus output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_adv) begin
            r_vpipe     <= {r_vpipe[c_VD-2:0], w_acc};
            r_out_valid <= r_vpipe[c_VD-1];
            if (r_vpipe[c_VD-1]) begin
                r_out_data <= w_aligned;
            end
        end
    end

`ifdef SYSA_PERF_EN
    logic [31:0] r_busy;
    logic [31:0] r_pstall;
    logic        w_job_start;

    assign w_job_start = (r_state == S_IDLE) &&
                         ((w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN));
    assign perf_busy   = r_busy;
    assign perf_stall  = r_pstall;

    // Saturating busy/stall counters, cleared when a job starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= '0;
            r_pstall <= '0;
        end else if (w_job_start) begin
            r_busy   <= '0;
            r_pstall <= '0;
        end else begin
            if (((r_state == S_RUN) || (r_state == S_DRAIN)) && (r_busy != 32'hFFFF_FFFF)) begin
                r_busy <= r_busy + 32'd1;
            end
            if (w_stall && (r_pstall != 32'hFFFF_FFFF)) begin
                r_pstall <= r_pstall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sysa_seq.sv
`default_nettype none
//============================================================================
// Module      : tb_sysa_seq
// Description : Self-checking bench for sysa_seq with a behavioural NxN
//               array model driving sa_out.
// Revision    : 1.0 - initial release
//============================================================================
module tb_sysa_seq;

    localparam int N   = 3;
    localparam int LAT = 2 * N + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              w_valid = 1'b0;
    logic              w_ready;
    logic [8*N-1:0]    w_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [8*N-1:0]    in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [16*N-1:0]   out_data;
    logic              done;
    logic              sa_en;
    logic [8*N*N-1:0]  sa_w;
    logic [8*N-1:0]    sa_in;
    logic [16*N-1:0]   sa_out;
`ifdef SYSA_PERF_EN
    logic [31:0]       perf_busy;
    logic [31:0]       perf_stall;
`endif

    sysa_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (done),
        .sa_en     (sa_en),
        .sa_w      (sa_w),
        .sa_in     (sa_in),
`ifdef SYSA_PERF_EN
        .perf_busy (perf_busy),
        .perf_stall(perf_stall),
`endif
        .sa_out    (sa_out)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_acc = 0;
    logic rnd_ready = 1'b0;
    logic [8*N*N-1:0] m_w = '0;
    logic [16*N-1:0]  sb[$];
    int               out_cyc[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Array environment: activations move right, partial sums move down.
    logic [7:0]  arr_a [N][N];
    logic [15:0] arr_p [N][N];
    logic [7:0]  pe_a  [N][N];
    logic [15:0] pe_p  [N][N];

    always_comb begin
        sa_out = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (c == 0) pe_a[r][c] = sa_in[8*r +: 8];
                else        pe_a[r][c] = arr_a[r][c-1];
                if (r == 0) pe_p[r][c] = 16'd0;
                else        pe_p[r][c] = arr_p[r-1][c];
            end
        end
        for (int c = 0; c < N; c++) begin
            sa_out[16*c +: 16] = arr_p[N-1][c];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    arr_a[r][c] <= '0;
                    arr_p[r][c] <= '0;
                end
            end
        end else if (sa_en) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    arr_a[r][c] <= pe_a[r][c];
                    arr_p[r][c] <= pe_p[r][c] + 16'(pe_a[r][c]) * 16'(sa_w[8*(r*N+c) +: 8]);
                end
            end
        end
    end

    // Reference: each result column is the weight-column dot product, mod 2^16.
    function automatic logic [16*N-1:0] model(input logic [8*N-1:0] a);
        logic [16*N-1:0] y;
        int unsigned     s;
        y = '0;
        for (int c = 0; c < N; c++) begin
            s = 0;
            for (int k = 0; k < N; k++) begin
                s += int'(a[8*k +: 8]) * int'(m_w[8*(k*N+c) +: 8]);
            end
            y[16*c +: 16] = s[15:0];
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: every consumed result must be the next expected one.
    initial begin
        logic [16*N-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got 0x%0h with nothing outstanding", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("result", out_data, e);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic load_w(input logic [8*N*N-1:0] wm);
        int n;
        for (int r = 0; r < N; r++) begin
            n = 0;
            w_valid = 1'b1;
            w_data  = wm[8*N*r +: 8*N];
            @(negedge clk);
            while (!w_ready && n < 200) begin n++; @(negedge clk); end
            chk("w_ready_wait", w_ready, 1);
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        m_w     = wm;
    endtask

    task automatic send_vec(input logic [8*N-1:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 300) begin n++; @(negedge clk); end
        chk("in_ready_wait", in_ready, 1);
        if (in_ready) begin
            sb.push_back(model(d));
            t_acc = cyc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin n++; @(negedge clk); end
        chk("out_valid_wait", out_valid, 1);
        lat = cyc - t_acc;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < bound) begin n++; @(negedge clk); end
        chk("done_pulse", done, 1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [8*N*N-1:0] w;
        logic [8*N-1:0]   a;
        logic [16*N-1:0]  y;
    } vec_t;

    vec_t tbl [5];
    localparam logic [8*N*N-1:0] c_IDENT = 72'h01_00_00_00_01_00_00_00_01;
    localparam logic [8*N*N-1:0] c_ONES  = 72'h01_01_01_01_01_01_01_01_01;

    initial begin
        int              lat;
        logic [16*N-1:0] d0;
        logic            seen;
        logic [8*N*N-1:0] wm;
        int              nv;

        tbl[0] = '{w: c_ONES,                   a: 24'h030201, y: 48'h0006_0006_0006};
        tbl[1] = '{w: c_IDENT,                  a: 24'h1E140A, y: 48'h001E_0014_000A};
        tbl[2] = '{w: 72'h030303_020202_010101, a: 24'h060504, y: 48'h0020_0020_0020};
        tbl[3] = '{w: 72'hFFFFFF_FFFFFF_FFFFFF, a: 24'hFFFFFF, y: 48'hFA03_FA03_FA03};
        tbl[4] = '{w: 72'h030201_030201_030201, a: 24'h030201, y: 48'h0012_000C_0006};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w_ready",   w_ready,   1);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done",      done,      0);
        chk("rst_sa_en",     sa_en,     0);
        chk("rst_sa_w",      sa_w,      0);
        chk("rst_sa_in",     sa_in,     0);
        chk("rst_out_data",  out_data,  0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table: single-vector jobs with fixed latency and hand-computed sums
        for (int i = 0; i < 5; i++) begin
            load_w(tbl[i].w);
            chk("sa_w_loaded", sa_w, tbl[i].w);
            send_vec(tbl[i].a, 1'b1);
            wait_out(lat);
            chk("latency", lat, LAT);
            chk("table_data", out_data, tbl[i].y);
            wait_done(50);
        end

        // Four back-to-back vectors through identity weights
        load_w(c_IDENT);
        out_cyc.delete();
        for (int v = 0; v < 4; v++) send_vec(24'(v * 24'h010203 + 24'h050607), v == 3);
        wait_done(100);
        chk("b2b_count", out_cyc.size(), 4);
        if (out_cyc.size() == 4) chk("b2b_span", out_cyc[3] - out_cyc[0], 3);

        // Same stream with 5-cycle backpressure at the first result
        out_ready = 1'b0;
        out_cyc.delete();
        for (int v = 0; v < 4; v++) send_vec(24'(v * 24'h111111 + 24'h102030), v == 3);
        wait_out(lat);
        d0 = out_data;
        for (int i = 0; i < 5; i++) begin
            chk("stall_sa_en",     sa_en,     0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data",  out_data,  d0);
            @(posedge clk); #1;
            if (i == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        wait_done(100);
        chk("stall_count", out_cyc.size(), 4);
        if (out_cyc.size() == 4) chk("stall_span", out_cyc[3] - out_cyc[0], 3);
        chk("stall_sb_empty", sb.size(), 0);

        // Weight beat during RUN is refused; vector during LOAD is refused
        send_vec(24'h030201, 1'b0);
        w_valid = 1'b1;
        w_data  = 24'hA5A5A5;
        repeat (2) begin
            @(negedge clk);
            chk("w_ready_in_run", w_ready, 0);
            chk("sa_w_in_run",    sa_w,    c_IDENT);
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        send_vec(24'h090807, 1'b1);
        wait_done(100);
        w_valid = 1'b1;
        w_data  = c_ONES[0 +: 24];
        @(posedge clk); #1;
        w_data   = c_ONES[24 +: 24];
        in_valid = 1'b1;
        in_data  = 24'h010101;
        @(negedge clk);
        chk("in_ready_in_load", in_ready, 0);
        chk("w_ready_in_load",  w_ready,  1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        w_data   = c_ONES[48 +: 24];
        @(posedge clk); #1;
        w_valid = 1'b0;
        m_w     = c_ONES;
        chk("sa_w_after_load", sa_w, c_ONES);

        // Reset with two vectors in flight
        send_vec(24'h0A0B0C, 1'b0);
        send_vec(24'h0D0E0F, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sa_en",     sa_en,     0);
        chk("mid_rst_sa_w",      sa_w,      0);
        chk("mid_rst_sa_in",     sa_in,     0);
        chk("mid_rst_out_data",  out_data,  0);
        chk("mid_rst_w_ready",   w_ready,   1);
        chk("mid_rst_in_ready",  in_ready,  0);
        sb.delete();
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("post_rst_quiet", seen, 0);
        @(posedge clk); #1;

        // Randomized jobs against the reference model
        rnd_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            for (int b = 0; b < N * N; b++) wm[8*b +: 8] = 8'($urandom);
            load_w(wm);
            nv = $urandom_range(1, 6);
            for (int v = 0; v < nv; v++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send_vec(24'($urandom), v == nv - 1);
            end
            wait_done(400);
        end
        rnd_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

`ifdef SYSA_PERF_EN
        // Perf counters over one job with a 3-cycle stall
        load_w(c_ONES);
        out_ready = 1'b0;
        send_vec(24'h030201, 1'b1);
        wait_out(lat);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(50);
        chk("perf_stall", perf_stall, 3);
        chk("perf_busy",  perf_busy,  2 * N + 2 + 3);
`endif

        repeat (3) @(posedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
